// File: rtl/uart_rx.sv
// uart_rx: oversampled serial receiver with a one-deep holding register.
// Define UART_RX_PARITY_EN for 8E1 frames with even-parity checking.
module uart_rx #(
    parameter int OVERSAMPLE = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_en,
    input  logic       rx,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       rdy,
    output logic       busy,
    output logic       frame_err,
    output logic       overrun,
    output logic       parity_err
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [2:0]     idx;
    logic [7:0]     shift;
    logic           rx_m;
    logic           rx_s;
    logic           good;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad;
    logic par_err_q;

    assign parity_err = par_err_q;
    assign good       = rx_s & ~par_bad;
`else
    assign parity_err = 1'b0;
    assign good       = rx_s;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shift     <= '0;
            data_out  <= '0;
            rdy       <= 1'b0;
            busy      <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad   <= 1'b0;
            par_err_q <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err_q <= 1'b0;
`endif
            // A delivery later in this block overrides the read clear
            if (rd_en) begin
                rdy <= 1'b0;
            end
            if (rx_en) begin
                unique case (state)
                    IDLE: begin
                        if (!rx_s) begin
                            state <= START;
                            cnt   <= '0;
                            busy  <= 1'b1;
                        end
                    end
                    START: begin
                        if (cnt == HALF_LAST) begin
                            cnt <= '0;
                            if (!rx_s) begin
                                state <= DATA;
                                idx   <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    DATA: begin
                        if (cnt == FULL_LAST) begin
                            cnt   <= '0;
                            shift <= {rx_s, shift[7:1]};
                            if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                idx <= idx + 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (cnt == FULL_LAST) begin
                            cnt     <= '0;
                            par_bad <= rx_s ^ (^shift);
                            state   <= STOP;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
`endif
                    STOP: begin
                        if (cnt == FULL_LAST) begin
                            cnt       <= '0;
                            state     <= IDLE;
                            busy      <= 1'b0;
                            frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                            par_err_q <= par_bad;
`endif
                            if (good) begin
                                data_out <= shift;
                                rdy      <= 1'b1;
                                overrun  <= rdy & ~rd_en;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
